opb_register_bank_ppc2simulink: RTL and testbench

- Parametrised successor to the single-register OPB-to-Simulink control register: a bank of NUM_REGS 32-bit software-writable, readable control registers behind one OPB slave window.
- Drives Simulink user logic (e.g. snap/phase control words) with per-register write strobes.
- Optional atomic multi-register commit.
- Single clock domain: user logic runs on OPB_Clk.

---
 rtl/opb_register_bank_ppc2simulink_pkg.sv | 43 ++++
 rtl/opb_reg_bank_slot.sv | 73 +++++++
 rtl/opb_register_bank_ppc2simulink.sv | 122 ++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared types and helpers for the OPB register bank: FSM states, OPB bit/byte-lane mapping, address decode.
package opb_reg_pkg;

  localparam int OPB_DWIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } opb_state_e;

  // OPB numbers bits MSB-first: DBus[0] carries register bit 31.
  function automatic logic [OPB_DWIDTH-1:0] opb_to_word(input logic [0:OPB_DWIDTH-1] d);
    logic [OPB_DWIDTH-1:0] w;
    for (int i = 0; i < OPB_DWIDTH; i++) begin
      w[OPB_DWIDTH-1-i] = d[i];
    end
    return w;
  endfunction

  function automatic logic [0:OPB_DWIDTH-1] word_to_opb(input logic [OPB_DWIDTH-1:0] w);
    logic [0:OPB_DWIDTH-1] d;
    for (int i = 0; i < OPB_DWIDTH; i++) begin
      d[i] = w[OPB_DWIDTH-1-i];
    end
    return d;
  endfunction

  // BE[0] enables register bits [31:24], BE[3] enables bits [7:0].
  function automatic logic [OPB_DWIDTH-1:0] be_to_mask(input logic [0:3] be);
    logic [OPB_DWIDTH-1:0] m;
    for (int b = 0; b < 4; b++) begin
      m[31-8*b -: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] offs;
    offs = addr - base;
    return {2'b00, offs[31:2]};
  endfunction

endpackage

// File: rtl/opb_reg_bank_slot.sv
// One control register with byte-masked write and a one-cycle update strobe.
// Shadow copy and dirty tracking exist only when OPB_REG_BANK_ATOMIC_COMMIT_EN is defined.
module opb_reg_bank_slot
  import opb_reg_pkg::*;
#(
  parameter logic [OPB_DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef OPB_REG_BANK_ATOMIC_COMMIT_EN
  input  logic                  i_commit,
`endif
  input  logic                  i_wr_en,
  input  logic [OPB_DWIDTH-1:0] i_wr_data,
  input  logic [OPB_DWIDTH-1:0] i_wr_mask,
  output logic [OPB_DWIDTH-1:0] o_value,
  output logic [OPB_DWIDTH-1:0] o_rd_value,
  output logic                  o_strobe
);

  logic [OPB_DWIDTH-1:0] r_value;
  logic                  r_strobe;
  logic [OPB_DWIDTH-1:0] w_merged;

`ifdef OPB_REG_BANK_ATOMIC_COMMIT_EN
  logic [OPB_DWIDTH-1:0] r_shadow;
  logic                  r_dirty;

  assign w_merged = (r_shadow & ~i_wr_mask) | (i_wr_data & i_wr_mask);

  // Software sees the shadow; user logic only sees it after a commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= RESET_VAL;
      r_dirty  <= 1'b0;
      r_value  <= RESET_VAL;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= i_commit & r_dirty;
      if (i_wr_en) begin
        r_shadow <= w_merged;
        r_dirty  <= 1'b1;
      end
      if (i_commit) begin
        r_value <= r_shadow;
        r_dirty <= 1'b0;
      end
    end
  end

  assign o_rd_value = r_shadow;
`else
  assign w_merged = (r_value & ~i_wr_mask) | (i_wr_data & i_wr_mask);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value  <= RESET_VAL;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= i_wr_en;
      if (i_wr_en) begin
        r_value <= w_merged;
      end
    end
  end

  assign o_rd_value = r_value;
`endif

  assign o_value  = r_value;
  assign o_strobe = r_strobe;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing NUM_REGS control registers to Simulink logic; two cycles per transfer, ack in the cycle after the hit.
// Optional atomic commit via control word at index NUM_REGS when OPB_REG_BANK_ATOMIC_COMMIT_EN is defined.
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h010B2000,
  parameter logic [31:0] C_HIGHADDR = 32'h010B20FF,
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [NUM_REGS*32-1:0]   user_data_out,
  output logic [NUM_REGS-1:0]      user_wr_strobe
);

  opb_state_e r_state;
  opb_state_e w_next;

  logic [31:0] r_idx;
  logic        r_rnw;
  logic [31:0] r_be_mask;
  logic [31:0] r_wdata;
  logic [31:0] r_rd_data;

  logic        w_hit;
  logic [31:0] w_idx;
  logic [31:0] w_rd_sel;
  logic        w_wr_go;
  logic        w_unused;
  logic [31:0] w_slot_rd [NUM_REGS];

  assign w_unused = OPB_seqAddr;

  assign w_hit = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign w_idx = addr_to_index(OPB_ABus, C_BASEADDR);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hit) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Indices past the last register (including the unused control slot) read as zero.
  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 32'(i)) w_rd_sel = w_slot_rd[i];
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      r_idx     <= '0;
      r_rnw     <= 1'b1;
      r_be_mask <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else if (r_state == IDLE && w_hit) begin
      r_idx     <= w_idx;
      r_rnw     <= OPB_RNW;
      r_be_mask <= be_to_mask(OPB_BE);
      r_wdata   <= opb_to_word(OPB_DBus);
      r_rd_data <= OPB_RNW ? w_rd_sel : '0;
    end
  end

  // A master that abandons the transfer during ACK loses its write.
  assign w_wr_go = (r_state == ACK) && !r_rnw && OPB_select;

`ifdef OPB_REG_BANK_ATOMIC_COMMIT_EN
  logic w_commit;
  assign w_commit = w_wr_go && (r_idx == 32'(NUM_REGS)) && r_wdata[0] && r_be_mask[0];
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    opb_reg_bank_slot #(
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .i_clk      (OPB_Clk),
      .i_rst_n    (OPB_Rst),
`ifdef OPB_REG_BANK_ATOMIC_COMMIT_EN
      .i_commit   (w_commit),
`endif
      .i_wr_en    (w_wr_go && (r_idx == 32'(i))),
      .i_wr_data  (r_wdata),
      .i_wr_mask  (r_be_mask),
      .o_value    (user_data_out[32*i +: 32]),
      .o_rd_value (w_slot_rd[i]),
      .o_strobe   (user_wr_strobe[i])
    );
  end

  assign Sl_xferAck = (r_state == ACK);
  assign Sl_DBus    = Sl_xferAck ? word_to_opb(r_rd_data) : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: ack timing, byte lanes, range handling, reset mid-transfer.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h010B2000;

  logic          clk;
  logic          rst_n;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus;
  logic          rnw;
  logic          sel;
  logic          seq;
  logic [0:31]   sl_dbus;
  logic          sl_ack;
  logic          sl_err;
  logic          sl_retry;
  logic          sl_tout;
  logic [127:0]  udo;
  logic [3:0]    stb;

  int n_checks = 0;
  int n_fail   = 0;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst_n),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (sl_ack),
    .Sl_errAck      (sl_err),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_tout),
    .user_data_out  (udo),
    .user_wr_strobe (stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One OPB beat; checks ack/data in N+1 and strobe in N+2.
  task automatic xfer(input string tag, input logic [31:0] addr, input logic r,
                      input logic [3:0] b, input logic [31:0] wd, input logic exp_ack,
                      input logic [31:0] exp_rd, input logic [3:0] exp_stb);
    @(posedge clk); #1;
    sel = 1'b1; abus = addr; rnw = r; be = b; dbus = wd;
    #1 check({tag, "_ack_n"}, sl_ack, 1'b0);
    @(posedge clk); #1;
    check({tag, "_ack"}, sl_ack, exp_ack);
    check({tag, "_dbus"}, sl_dbus, (r && exp_ack) ? exp_rd : 32'h0);
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b1; be = 4'h0; dbus = '0; abus = '0;
    check({tag, "_ack_off"}, sl_ack, 1'b0);
    check({tag, "_dbus_off"}, sl_dbus, 32'h0);
    check({tag, "_stb"}, stb, exp_stb);
    @(posedge clk); #1;
    check({tag, "_stb_off"}, stb, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0; abus = '0; seq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", sl_ack, 1'b0);
    check("rst_dbus", sl_dbus, 32'h0);
    check("rst_udo", udo, 128'h0);
    check("rst_stb", stb, 4'h0);
    check("tied_0", {sl_err, sl_retry, sl_tout}, 3'b000);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      xfer($sformatf("rd_init%0d", i), BASE + 32'(4*i), 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);
    end
    check("udo_init", udo, 128'h0);

    xfer("wr_full", BASE + 32'h4, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0, 4'b0010);
    check("udo_wr_full", udo, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    xfer("rd_full", BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 4'h0);

    xfer("wr_lane1", BASE + 32'h4, 1'b0, 4'b0100, 32'h11223344, 1'b1, 32'h0, 4'b0010);
    xfer("rd_lane1", BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDE22BEEF, 4'h0);
    xfer("wr_be0", BASE + 32'h4, 1'b0, 4'b0000, 32'hFFFFFFFF, 1'b1, 32'h0, 4'b0010);
    xfer("rd_be0", BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b1, 32'hDE22BEEF, 4'h0);

    xfer("wr_r3", BASE + 32'hC, 1'b0, 4'b1001, 32'h12345678, 1'b1, 32'h0, 4'b1000);
    xfer("rd_r3", BASE + 32'hC, 1'b1, 4'hF, 32'h0, 1'b1, 32'h12000078, 4'h0);
    check("udo_r3", udo, {32'h12000078, 32'h0, 32'hDE22BEEF, 32'h0});

    xfer("rd_idx16", BASE + 32'h40, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);
    xfer("wr_idx16", BASE + 32'h40, 1'b0, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 4'h0);
    xfer("rd_out", BASE + 32'h100, 1'b1, 4'hF, 32'h0, 1'b0, 32'h0, 4'h0);
    xfer("wr_out", BASE + 32'h100, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0, 4'h0);
    check("udo_range", udo, {32'h12000078, 32'h0, 32'hDE22BEEF, 32'h0});

`ifndef OPB_REG_BANK_ATOMIC_COMMIT_EN
    xfer("wr_idx4", BASE + 32'h10, 1'b0, 4'hF, 32'h1, 1'b1, 32'h0, 4'h0);
    xfer("rd_idx4", BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);
    check("udo_idx4", udo, {32'h12000078, 32'h0, 32'hDE22BEEF, 32'h0});
`endif

    // Master drops select during ACK: ack completes, write discarded.
    @(posedge clk); #1;
    sel = 1'b1; abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'h55555555;
    @(posedge clk); #1;
    sel = 1'b0;
    check("drop_ack", sl_ack, 1'b1);
    @(posedge clk); #1;
    check("drop_stb", stb, 4'h0);
    check("drop_ack_off", sl_ack, 1'b0);
    check("drop_udo", udo[31:0], 32'h0);
    rnw = 1'b1; be = '0; dbus = '0; abus = '0;

    // Reset asserted in the ACK cycle of a write.
    @(posedge clk); #1;
    sel = 1'b1; abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("rstack_ack", sl_ack, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstack_ack_drop", sl_ack, 1'b0);
    check("rstack_udo", udo, 128'h0);
    @(posedge clk); #1;
    sel = 1'b0; rnw = 1'b1; be = '0; dbus = '0; abus = '0;
    check("rstack_stb", stb, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    xfer("rstack_rd0", BASE, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);
    xfer("rstack_rd1", BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);

`ifdef OPB_REG_BANK_ATOMIC_COMMIT_EN
    xfer("at_wr0", BASE, 1'b0, 4'hF, 32'h0000000A, 1'b1, 32'h0, 4'h0);
    xfer("at_wr2", BASE + 32'h8, 1'b0, 4'hF, 32'h0000000C, 1'b1, 32'h0, 4'h0);
    check("at_udo_pre", udo, 128'h0);
    xfer("at_rd0", BASE, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0000000A, 4'h0);
    xfer("at_commit", BASE + 32'h10, 1'b0, 4'hF, 32'h1, 1'b1, 32'h0, 4'b0101);
    check("at_udo_post", udo, {32'h0, 32'h0000000C, 32'h0, 32'h0000000A});
    xfer("at_rd_ctl", BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1'b1, 32'h0, 4'h0);
    xfer("at_recommit", BASE + 32'h10, 1'b0, 4'hF, 32'h1, 1'b1, 32'h0, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
